lsu_bus_adapter: RTL and testbench

- Load/store unit between the multi-cycle control unit and the word-addressed data bus.
- Control unit drives it during store/load memory states via busWe, memSize and memUnsigned.
- For stores: builds byte strobes and replicated write data. For loads: extracts the byte/half lane and sign- or zero-extends it.
- Runs a valid/ready handshake with the bus, flags misaligned or timed-out accesses, and reports busy/done so the control FSM can stall.

---
 rtl/lsu_bus_adapter_pkg.sv | 10 +
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/lsu_bus_adapter.sv | 129 ++++++++++++
 tb/tb_lsu_bus_adapter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_adapter_pkg.sv
// Shared encodings for the load/store bus adapter: access sizes and FSM states.
package lsu_bus_adapter_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store strobes/replication, load lane extract and
// extension, and alignment check for one access.
module lsu_lane_align
  import lsu_bus_adapter_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  always_comb begin
    strb       = 4'b1111;
    wdata_rep  = wdata;
    load_data  = bus_rdata;
    misaligned = 1'b0;
    sext       = 1'b0;
    case (size)
      MEM_BYTE: begin
        strb      = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        sext      = ~uns & lane_b[7];
        load_data = {{24{sext}}, lane_b};
      end
      MEM_HALF: begin
        strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        sext       = ~uns & lane_h[15];
        load_data  = {{16{sext}}, lane_h};
        misaligned = addr_lo[0];
      end
      // 2'b11 is handled as a word access
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit bridging the multi-cycle control FSM to the word-addressed
// valid/ready data bus, with misalignment and timeout abort.
module lsu_bus_adapter
  import lsu_bus_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_strb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  lsu_state_e  state;
  logic [15:0] cnt;
  logic [1:0]  lat_lo;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic        lat_we;

  logic [1:0]  sel_lo;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_mis;

  // In IDLE the aligner sees the live request; afterwards it sees the latched one.
  assign sel_lo   = (state == IDLE) ? addr[1:0]   : lat_lo;
  assign sel_size = (state == IDLE) ? memSize     : lat_size;
  assign sel_uns  = (state == IDLE) ? memUnsigned : lat_uns;

  lsu_lane_align u_align (
    .addr_lo    (sel_lo),
    .size       (sel_size),
    .uns        (sel_uns),
    .wdata      (wdata),
    .bus_rdata  (bus_rdata),
    .strb       (al_strb),
    .wdata_rep  (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_lo    <= '0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
      lat_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_strb  <= '0;
      bus_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_lo   <= addr[1:0];
            lat_size <= memSize;
            lat_uns  <= memUnsigned;
            lat_we   <= we;
            busy     <= 1'b1;
            if (al_mis) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ERR;
            end else begin
              bus_valid <= 1'b1;
              bus_we    <= we;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_strb  <= al_strb;
              bus_wdata <= al_wdata;
              cnt       <= '0;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!lat_we) rdata <= al_load;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus_valid <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            state     <= ERR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: stores, loads, misalignment, wait states,
// timeout and asynchronous reset mid-transfer.
module tb_lsu_bus_adapter;
  import lsu_bus_adapter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, memUnsigned;
  logic [31:0] addr, wdata;
  logic [1:0]  memSize;
  logic        busy, done, err, bus_valid, bus_ready, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_strb;

  logic        ready_en;
  int          rdy_delay;
  int          vcnt;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          lat;
  logic        saw_valid, unstable, got_err;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_strb;
  logic        s_we;

  lsu_bus_adapter #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .memSize(memSize), .memUnsigned(memUnsigned), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_strb(bus_strb),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Slave model: ready rises after rdy_delay cycles of pending valid.
  always @(posedge clk) begin
    if (bus_valid && !bus_ready) vcnt <= vcnt + 1;
    else if (!bus_valid)         vcnt <= 0;
  end
  assign bus_ready = ready_en && (vcnt >= rdy_delay);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic u);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; memSize = sz; memUnsigned = u;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1; saw_valid = 1'b0; unstable = 1'b0;
    s_addr = bus_addr; s_wdata = bus_wdata; s_strb = bus_strb; s_we = bus_we;
    while (!done && lat < 60) begin
      if (bus_valid) begin
        saw_valid = 1'b1;
        if (bus_addr !== s_addr || bus_wdata !== s_wdata ||
            bus_strb !== s_strb || bus_we !== s_we) unstable = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check("done_wait", 32'(done), 32'd1);
    got_err = err;
    @(posedge clk); #1;
    check("done_pulse_end", {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    memSize = MEM_WORD; memUnsigned = 1'b0; bus_rdata = '0;
    ready_en = 1'b1; rdy_delay = 0; vcnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr",  bus_addr, 32'd0);
    check("rst_strb",  32'(bus_strb), 32'd0);
    @(negedge clk); reset = 1'b0;

    // sb
    run(1'b1, 32'h0000_1003, 32'h0000_00A5, MEM_BYTE, 1'b0);
    check("sb_addr",  s_addr, 32'h0000_1000);
    check("sb_strb",  32'(s_strb), 32'h8);
    check("sb_wdata", s_wdata, 32'hA5A5_A5A5);
    check("sb_we",    32'(s_we), 32'd1);
    check("sb_lat",   lat, 2);
    check("sb_err",   32'(got_err), 32'd0);
    check("sb_rdata", rdata, 32'd0);

    // byte loads
    bus_rdata = 32'h80FF_7F01;
    run(1'b0, 32'h0000_2002, 32'h0, MEM_BYTE, 1'b0);
    check("lb2_rdata", rdata, 32'hFFFF_FFFF);
    check("lb2_strb",  32'(s_strb), 32'h4);
    check("lb2_we",    32'(s_we), 32'd0);
    run(1'b0, 32'h0000_2003, 32'h0, MEM_BYTE, 1'b1);
    check("lbu3_rdata", rdata, 32'h0000_0080);
    run(1'b0, 32'h0000_2000, 32'h0, MEM_BYTE, 1'b0);
    check("lb0_rdata", rdata, 32'h0000_0001);

    // half loads
    bus_rdata = 32'h8001_7FFE;
    run(1'b0, 32'h0000_2002, 32'h0, MEM_HALF, 1'b0);
    check("lh2_rdata", rdata, 32'hFFFF_8001);
    check("lh2_strb",  32'(s_strb), 32'hC);
    run(1'b0, 32'h0000_2002, 32'h0, MEM_HALF, 1'b1);
    check("lhu2_rdata", rdata, 32'h0000_8001);
    run(1'b0, 32'h0000_2000, 32'h0, MEM_HALF, 1'b0);
    check("lh0_rdata", rdata, 32'h0000_7FFE);
    check("lh0_strb",  32'(s_strb), 32'h3);

    // word loads, including size code 11
    run(1'b0, 32'h0000_2000, 32'h0, MEM_WORD, 1'b0);
    check("lw_rdata", rdata, 32'h8001_7FFE);
    check("lw_strb",  32'(s_strb), 32'hF);
    bus_rdata = 32'h1357_9BDF;
    run(1'b0, 32'h0000_2004, 32'h0, 2'b11, 1'b1);
    check("lw11_rdata", rdata, 32'h1357_9BDF);
    check("lw11_addr",  s_addr, 32'h0000_2004);

    // misaligned
    run(1'b0, 32'h0000_3002, 32'h0, MEM_WORD, 1'b0);
    check("mis_lw_valid", 32'(saw_valid), 32'd0);
    check("mis_lw_lat",   lat, 1);
    check("mis_lw_err",   32'(got_err), 32'd1);
    check("mis_lw_rdata", rdata, 32'h1357_9BDF);
    run(1'b1, 32'h0000_3001, 32'hFFFF_FFFF, MEM_HALF, 1'b0);
    check("mis_sh_valid", 32'(saw_valid), 32'd0);
    check("mis_sh_lat",   lat, 1);
    check("mis_sh_err",   32'(got_err), 32'd1);

    // three wait states
    rdy_delay = 3;
    run(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, MEM_WORD, 1'b0);
    check("ws_lat",      lat, 5);
    check("ws_stable",   32'(unstable), 32'd0);
    check("ws_wdata",    s_wdata, 32'hDEAD_BEEF);
    check("ws_strb",     32'(s_strb), 32'hF);
    check("ws_err",      32'(got_err), 32'd0);
    check("ws_rdata",    rdata, 32'h1357_9BDF);
    rdy_delay = 0;

    // sh store lane replication
    run(1'b1, 32'h0000_4002, 32'h1234_ABCD, MEM_HALF, 1'b0);
    check("sh_strb",  32'(s_strb), 32'hC);
    check("sh_wdata", s_wdata, 32'hABCD_ABCD);

    // timeout with ready stuck low
    ready_en = 1'b0;
    run(1'b0, 32'h0000_5000, 32'h0, MEM_WORD, 1'b0);
    check("to_lat",   lat, 5);
    check("to_err",   32'(got_err), 32'd1);
    check("to_rdata", rdata, 32'h1357_9BDF);
    check("to_valid", 32'(bus_valid), 32'd0);

    // asynchronous reset in the middle of a bus cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_5000; memSize = MEM_WORD;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_mid_pre_valid", 32'(bus_valid), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus_valid), 32'd0);
    check("rst_mid_busy",  32'(busy), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    @(negedge clk); reset = 1'b0; ready_en = 1'b1;
    run(1'b1, 32'h0000_6001, 32'h0000_005A, MEM_BYTE, 1'b0);
    check("post_rst_addr",  s_addr, 32'h0000_6000);
    check("post_rst_strb",  32'(s_strb), 32'h2);
    check("post_rst_wdata", s_wdata, 32'h5A5A_5A5A);
    check("post_rst_lat",   lat, 2);
    check("post_rst_err",   32'(got_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
